nios_led_mem_master: RTL and testbench

Avalon-MM initiator that drives the single-port on-chip memory slave (32-bit data, 12-bit word address, registered address, unregistered read data, clken-gated) from a simple command/stream interface. It executes block write and block read commands of 0..2^CNT_W-1 words, moving write data in from a valid/ready stream and read data out on a valid/ready stream. Read backpressure is applied by deasserting the memory clock enable, so no output buffer is needed. It sits between the UART command handler logic and the memory's s2 port.

---
 rtl/nios_led_mem_master_pkg.sv | 21 ++
 rtl/nios_led_mem_master_addr_gen.sv | 40 ++++
 rtl/nios_led_mem_master.sv | 180 ++++++++++++++++++
 tb/tb_nios_led_mem_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_led_mem_master_pkg.sv
// Shared constants and state encoding for the nios_led_mem_master block.
// Optional feature macro: NIOS_LED_MEM_MASTER_CHECKSUM_EN (see top module).
package nios_led_mem_master_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int BE_W_DEF     = DATA_W_DEF / 8;
  localparam int CNT_W_DEF    = 13;

  // One cycle between an address being issued and its word appearing on q.
  localparam int READ_LATENCY = 1;

  // Controller states, kept as plain constants so older tools and
  // wave viewers see a simple 2-bit code.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t WRITE = 2'd1;
  localparam state_t READ  = 2'd2;
  localparam state_t DRAIN = 2'd3;

endpackage

// File: rtl/nios_led_mem_master_addr_gen.sv
// Address / word-count generator for nios_led_mem_master.
// Loads a start address and length, then steps the address (wrapping
// modulo 2^ADDR_W) and counts down the remaining words.
module nios_led_mem_master_addr_gen
  import nios_led_mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]  load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  remaining,
  output logic              last,
  output logic              step
);

  assign step = advance && (remaining != '0);
  assign last = (remaining == CNT_W'(1));

  // Load on command accept, otherwise step once per transferred word;
  // the natural ADDR_W-bit overflow gives the required wrap-around.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios_led_mem_master.sv
// Avalon-MM initiator for the single-port on-chip memory (s2 port).
// Runs block write / block read commands from a command interface, taking
// write words from a valid/ready stream and delivering read words on a
// valid/ready stream. Read backpressure stalls the memory through clken,
// so read data is passed straight through with no output buffer.
// Optional feature macro: NIOS_LED_MEM_MASTER_CHECKSUM_EN enables a running
// sum of every transferred word on 'checksum'; otherwise checksum is 0.
module nios_led_mem_master
  import nios_led_mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [BE_W-1:0]   cmd_byteenable,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  state_t                   state;
  state_t                   state_next;
  logic                     ready_en;
  logic [BE_W-1:0]          be_q;
  logic [READ_LATENCY-1:0]  rd_pend;
  logic [ADDR_W-1:0]        addr;
  logic [CNT_W-1:0]         remaining;
  logic                     last;
  logic                     step;
  logic                     accept;
  logic                     write_hs;
  logic                     rd_hs;
  logic                     advance;
  logic                     issue;
  logic                     done_next;

  assign rd_valid  = rd_pend[READ_LATENCY-1];
  assign cmd_ready = ready_en && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign write_hs  = (state == WRITE) && wr_valid;
  assign rd_hs     = rd_valid && rd_ready;

  // A pending word that the consumer will not take this cycle freezes the
  // memory, holding q and leaving the next address unconsumed.
  assign avm_clken = !(rd_valid && !rd_ready);
  assign advance   = write_hs || ((state == READ) && avm_clken);
  assign issue     = step && (state == READ);

  assign wr_ready       = (state == WRITE);
  assign avm_write      = write_hs;
  assign avm_chipselect = write_hs || (state == READ);
  assign avm_address    = addr;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wr_data;
  assign rd_data        = avm_readdata;
  assign busy           = (state != IDLE);

  assign done_next = (accept && (cmd_len == '0))
                   || (write_hs && last)
                   || ((state == DRAIN) && rd_hs);

  nios_led_mem_master_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .advance   (advance),
    .addr      (addr),
    .remaining (remaining),
    .last      (last),
    .step      (step)
  );

  // Next-state decode: zero-length commands never leave IDLE, reads pass
  // through DRAIN so the final word can still be handed off.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept && (cmd_len != '0)) begin
          state_next = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (write_hs && last) begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (issue && last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, with the reset discarding any in-flight command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control flags: command-ready enable, done pulse, read-valid tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      done     <= 1'b0;
      rd_pend  <= '0;
    end else begin
      ready_en <= 1'b1;
      done     <= done_next;
      if (issue) begin
        rd_pend <= '1;
      end else if (rd_hs) begin
        rd_pend <= '0;
      end
    end
  end

  // Byteenable is fixed for the whole command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= cmd_byteenable;
    end
  end

`ifdef NIOS_LED_MEM_MASTER_CHECKSUM_EN
  // Running sum of every word moved by the current command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (write_hs) begin
      checksum <= checksum + wr_data;
    end else if (rd_hs) begin
      checksum <= checksum + avm_readdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios_led_mem_master.sv
// Self-checking bench for nios_led_mem_master with an on-chip memory model
// and a high-level expected-contents array.
module tb_nios_led_mem_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic [3:0]  cmd_byteenable;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [11:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_clken;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int total;
  int bad;

  logic [31:0] mem [0:4095];
  logic [11:0] memAddrQ;
  logic        memInit;

  logic [31:0] refMem [0:4095];
  logic [31:0] wrWords [0:63];

  nios_led_mem_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_byteenable (cmd_byteenable),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // On-chip memory slave: registered address gated by clken, unregistered q.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      memAddrQ <= '0;
    end else if (avm_clken) begin
      memAddrQ <= avm_address;
      if (avm_chipselect && avm_write) begin
        for (int b = 0; b < 4; b++) begin
          if (avm_byteenable[b]) mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
        end
      end
    end
  end
  assign avm_readdata = mem[memAddrQ];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic stallPattern(input int k);
    logic [5:0] p;
    p = 6'b101001;
    if (k >= 1 && k <= 6) return p[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] expectSum(input logic [31:0] s);
`ifdef NIOS_LED_MEM_MASTER_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  // mode: 0 = always ready/valid, 1 = fixed read stall pattern, 2 = random gaps
  task automatic applyStimulus(input logic isWrite, input logic [11:0] addr, input int len,
                               input logic [3:0] be, input int mode, input logic checkTiming);
    int xfer;
    int lastXfer;
    int budget;
    logic seenDone;
    logic [31:0] sum;
    logic [11:0] a;
    step();
    cmd_valid      = 1'b1;
    cmd_write      = isWrite;
    cmd_addr       = addr;
    cmd_len        = 13'(len);
    cmd_byteenable = be;
    wr_valid       = 1'b0;
    rd_ready       = 1'b1;
    #1;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    xfer = 0; lastXfer = 0; seenDone = 1'b0; sum = '0;
    budget = 30 * len + 20;
    for (int k = 1; k <= budget && !seenDone; k++) begin
      step();
      cmd_valid      = busy ? 1'($urandom % 2) : 1'b0;
      cmd_write      = 1'($urandom % 2);
      cmd_addr       = 12'($urandom);
      cmd_len        = 13'($urandom_range(1, 20));
      cmd_byteenable = 4'($urandom);
      if (isWrite) begin
        wr_valid = (mode == 0) ? 1'b1 : 1'($urandom % 4 != 0);
        wr_data  = (xfer < 64) ? wrWords[xfer] : $urandom;
        rd_ready = 1'($urandom % 2);
      end else begin
        wr_valid = 1'($urandom % 2);
        wr_data  = $urandom;
        rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? stallPattern(k) : 1'($urandom % 3 != 0);
      end
      #1;
      if (done) begin
        seenDone = 1'b1;
        checkOutput("xfer_count", 32'(xfer), 32'(len));
        checkOutput("done_after_last", 32'(k), 32'(lastXfer + 1));
        if (checkTiming)
          checkOutput("done_cycle", 32'(k), 32'((isWrite || len == 0) ? len + 1 : len + 2));
        checkOutput("ready_at_done", 32'(cmd_ready), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("cs_at_done", 32'(avm_chipselect), 32'd0);
        checkOutput("checksum", checksum, expectSum(sum));
      end else begin
        checkOutput("ready_while_busy", 32'(cmd_ready), 32'd0);
        a = addr + 12'(xfer);
        if (isWrite) begin
          if (wr_valid) begin
            checkOutput("wr_ready", 32'(wr_ready), 32'd1);
            checkOutput("wr_cs", 32'(avm_chipselect && avm_write), 32'd1);
            checkOutput("wr_addr", 32'(avm_address), 32'(a));
            checkOutput("wr_data", avm_writedata, wr_data);
            checkOutput("wr_be", 32'(avm_byteenable), 32'(be));
            for (int b = 0; b < 4; b++) begin
              if (be[b]) refMem[a][8*b +: 8] = wr_data[8*b +: 8];
            end
            sum = sum + wr_data;
            xfer++;
            lastXfer = k;
          end else begin
            checkOutput("wr_gap_cs", 32'(avm_chipselect), 32'd0);
          end
        end else begin
          checkOutput("rd_no_write", 32'(avm_write), 32'd0);
          checkOutput("clken", 32'(avm_clken), 32'(!(rd_valid && !rd_ready)));
          if (rd_valid && rd_ready) begin
            checkOutput("rd_data", rd_data, refMem[a]);
            sum = sum + refMem[a];
            xfer++;
            lastXfer = k;
          end
        end
      end
    end
    if (!seenDone) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    checkOutput({tag, "_write"}, 32'(avm_write), 32'd0);
    checkOutput({tag, "_clken"}, 32'(avm_clken), 32'd1);
    checkOutput({tag, "_addr"}, 32'(avm_address), 32'd0);
    checkOutput({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    logic [11:0] rAddr;
    int          rLen;
    int          rMode;
    logic        rWrite;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) refMem[i] = '0;
    reset_n = 1'b0; memInit = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_byteenable = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
    step();
    step();
    checkResetValues("reset");
    memInit = 1'b0;
    reset_n = 1'b1;
    step();
    checkOutput("ready_after_release", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 4; i++) wrWords[i] = 32'hA0 + 32'(i);
    applyStimulus(1'b1, 12'h010, 4, 4'hF, 0, 1'b1);
    applyStimulus(1'b0, 12'h010, 4, 4'hF, 0, 1'b1);
    applyStimulus(1'b0, 12'h010, 4, 4'hF, 1, 1'b0);

    for (int i = 0; i < 3; i++) wrWords[i] = $urandom;
    applyStimulus(1'b1, 12'hFFF, 3, 4'hF, 0, 1'b1);
    applyStimulus(1'b0, 12'hFFF, 3, 4'hF, 0, 1'b1);

    applyStimulus(1'b1, 12'h123, 0, 4'hF, 0, 1'b1);
    applyStimulus(1'b0, 12'h456, 0, 4'hF, 0, 1'b1);

    for (int i = 0; i < 4; i++) wrWords[i] = $urandom;
    applyStimulus(1'b1, 12'h010, 4, 4'h5, 2, 1'b0);
    applyStimulus(1'b0, 12'h00E, 8, 4'hF, 2, 1'b0);

    // Reset in cycle 2 of an 8-word read
    step();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 13'd8; rd_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    checkResetValues("midreset");
    step();
    #1;
    checkOutput("midreset_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("midreset_no_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 12'h011, 2, 4'hF, 0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      rWrite = 1'($urandom % 2);
      rAddr  = (t % 3 == 0) ? 12'($urandom_range(4080, 4095)) : 12'($urandom_range(0, 63));
      rLen   = $urandom_range(0, 40);
      rMode  = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) wrWords[i] = $urandom;
      applyStimulus(rWrite, rAddr, rLen, 4'($urandom), rMode, rMode == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
